// File: rtl/matrix_stream_writer.sv
// matrix_stream_writer
// Writes one matrix into its BRAM slot. The slot holds three header words
// (dimensions, then two words of name), followed by the elements in row-major order.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for write_request; write_ready high
// HDR0   | write {rows, cols, 16'h0} to base
// HDR1   | write name bytes 0..3 to base+1
// HDR2   | write name bytes 4..7 to base+2
// STREAM | accept elements on data_valid, write to base+3+elem_cnt
// DONE   | one-cycle write_done pulse
// ERR    | one-cycle write_error pulse for a rejected request

module matrix_stream_writer #(
  parameter int SLOT_WORDS = 1152,
  parameter int MAX_ELEMS  = 1149
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_request,
  output logic        write_ready,
  input  logic [2:0]  matrix_id,
  input  logic [7:0]  actual_rows,
  input  logic [7:0]  actual_cols,
  input  logic [7:0]  matrix_name [0:7],
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        writer_ready,
  output logic        write_done,
  output logic        write_error,
  output logic        bram_we,
  output logic [13:0] bram_addr,
  output logic [31:0] bram_din
);

  localparam logic [15:0] MAX_TOTAL = 16'(MAX_ELEMS);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    STREAM,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  id_q;
  logic [7:0]  rows_q;
  logic [7:0]  cols_q;
  logic [7:0]  name_q [0:7];
  logic [15:0] total_q;
  logic [15:0] elem_cnt;

  logic [13:0] base;
  logic [15:0] req_total;
  logic        req_bad;
  logic        accept;
  logic        last_elem;

  // The slot base follows the latched id, so clearing the id also clears the base.
  assign base      = 14'(32'(id_q) * SLOT_WORDS);
  assign req_total = 16'(actual_rows) * 16'(actual_cols);
  assign req_bad   = (matrix_id == 3'd0) || (actual_rows == 8'd0) ||
                     (actual_cols == 8'd0) || (req_total > MAX_TOTAL);
  assign accept    = (state == STREAM) && data_valid;
  assign last_elem = (elem_cnt == (total_q - 16'd1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the request parameters when a request is taken in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= 3'd0;
      rows_q  <= 8'd0;
      cols_q  <= 8'd0;
      total_q <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        name_q[i] <= 8'd0;
      end
    end else if ((state == IDLE) && write_request) begin
      id_q    <= matrix_id;
      rows_q  <= actual_rows;
      cols_q  <= actual_cols;
      total_q <= req_total;
      for (int i = 0; i < 8; i++) begin
        name_q[i] <= matrix_name[i];
      end
    end
  end

  // Element counter: advances per accepted element and is cleared at DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= 16'd0;
    end else if (state == DONE) begin
      elem_cnt <= 16'd0;
    end else if (accept) begin
      elem_cnt <= elem_cnt + 16'd1;
    end
  end

  // Next-state logic and the BRAM write port; element writes are combinational
  // so an element lands in the same cycle it is accepted.
  always_comb begin
    state_nxt    = state;
    write_ready  = 1'b0;
    writer_ready = 1'b0;
    write_done   = 1'b0;
    write_error  = 1'b0;
    bram_we      = 1'b0;
    bram_addr    = 14'd0;
    bram_din     = 32'd0;
    case (state)
      IDLE: begin
        write_ready = 1'b1;
        if (write_request) begin
          state_nxt = req_bad ? ERR : HDR0;
        end
      end
      HDR0: begin
        bram_we   = 1'b1;
        bram_addr = base;
        bram_din  = {rows_q, cols_q, 16'h0000};
        state_nxt = HDR1;
      end
      HDR1: begin
        bram_we   = 1'b1;
        bram_addr = base + 14'd1;
        bram_din  = {name_q[0], name_q[1], name_q[2], name_q[3]};
        state_nxt = HDR2;
      end
      HDR2: begin
        bram_we   = 1'b1;
        bram_addr = base + 14'd2;
        bram_din  = {name_q[4], name_q[5], name_q[6], name_q[7]};
        state_nxt = STREAM;
      end
      STREAM: begin
        writer_ready = 1'b1;
        if (data_valid) begin
          bram_we   = 1'b1;
          bram_addr = base + 14'd3 + elem_cnt[13:0];
          bram_din  = data_in;
          if (last_elem) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        write_done = 1'b1;
        state_nxt  = IDLE;
      end
      ERR: begin
        write_error = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
